multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multicycle RV32I datapath, which replaces the single-cycle top.
- It sequences one shared memory port (instruction and data), one ALU and the register file across several cycles per instruction.
- It decodes `op` and drives all datapath mux selects and write enables.
- It supports memory wait states via `mem_ready`.
- Instruction subset: R-type, I-type ALU, LW, SW, BEQ, JAL, LUI.

Parameters:
- ENABLE_MEM_WAIT, 1: when 0, `mem_ready` is ignored and treated as constant 1.
- STATE_W, 4: width of the state register and of the `state` debug output.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- op  in  7  opcode field of the instruction register (IR[6:0]).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC register load enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = Result.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction-register and OldPC load enable.
- reg_write  out  1  register-file write enable.
- result_src  out  2  Result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  SrcA select: 00 = PC, 01 = OldPC, 10 = A register, 11 = zero.
- alu_src_b  out  2  SrcB select: 00 = B register, 01 = ImmExt, 10 = constant 4.
- alu_op  out  2  ALU decoder op: 00 = add, 01 = sub, 10 = decode funct fields.
- imm_src  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state  out  STATE_W  current state, for the bench.

Behaviour:
- Outputs are Moore decodes of the state register. Exceptions:
  - `pc_write` also depends on `zero`.
  - Memory enables and the FETCH enables depend on `mem_ready`.
  - `imm_src` is decoded combinationally from `op` in every state; unknown op gives 000.
- Reset:
  - While rst=1, `pc_write`, `mem_write`, `ir_write`, `reg_write`, `instr_done` and `illegal_op` are forced to 0.
  - The state register loads FETCH on the clock edge where rst=1.
  - Reset mid-instruction abandons it; no partial write completes after that edge.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, LUI=11. Codes 12–15 go to FETCH on the next edge and assert no enables.
- Defaults, unless a state says otherwise: all enables 0, adr_src=0, result_src=00, alu_src_a=00, alu_src_b=00, alu_op=00.
- FETCH:
  - adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while !mem_ready; goes to DECODE when mem_ready.
- DECODE:
  - alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut).
  - Next state by op:
    - 0000011 (LW) or 0100011 (SW) → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - 0110111 → LUI
    - any other op → FETCH, with illegal_op=1 and instr_done=1 this cycle.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Holds until mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Goes to FETCH.
- MEMWRITE:
  - adr_src=1, result_src=00, mem_write=1 held high every cycle until mem_ready.
  - instr_done = mem_ready.
  - Goes to FETCH when mem_ready.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Goes to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Goes to ALUWB.
- LUI: alu_src_a=11, alu_src_b=01, alu_op=00. Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Goes to FETCH.
- BEQ:
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write = zero; instr_done=1.
  - Goes to FETCH.
- JAL:
  - alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1.
  - Goes to ALUWB, which writes rd = OldPC+4.
- Cycle counts with mem_ready always 1: R, I and LUI take 4; LW 5; SW 4; BEQ 3; JAL 4. Each memory wait cycle adds exactly one cycle.
- `op` is sampled only in DECODE, MEMADR and the imm_src decode. IR is stable outside FETCH.

Test Plan:
- Reset: rst=1 for 2 cycles with op=0110011 → all enables 0, state=0. After release: ir_write=1, pc_write=1 in the first cycle.
- Straight-line program `addi x1,x0,5` / `add x2,x1,x1` / `lui x3,0x12345`, mem_ready=1 → each takes 4 cycles. instr_done at cycles 4, 8, 12; reg_write only in ALUWB; LUI shows alu_src_a=11.
- LW (0x00402203) with mem_ready low 2 cycles in FETCH and 3 in MEMREAD → total 10 cycles. ir_write is a single pulse; reg_write pulses once with result_src=01.
- SW (0x00302423) with mem_ready low 2 cycles in MEMWRITE → mem_write high 3 consecutive cycles, adr_src=1; instr_done only on the third.
- BEQ with zero=1 and then zero=0 → pc_write=1 in state 9 for the first, 0 for the second; both take 3 cycles. JAL → pc_write in state 10, reg_write in ALUWB.
- op=0000000 in DECODE → illegal_op and instr_done pulse once, next state FETCH. Assert rst in MEMWRITE → mem_write drops the same cycle and state=0 after the edge.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - main control FSM for the multicycle RV32I datapath
// Sequences the shared memory port, ALU and register file; outputs are state decodes.
module multicycle_ctrl_fsm #(
   parameter bit ENABLE_MEM_WAIT = 1'b1,
   parameter int STATE_W         = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         op,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               adr_src,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_write,
   output logic [1:0]         result_src,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [2:0]         imm_src,
   output logic               instr_done,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_LUI      = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   state_t state_q, state_n;
   logic   ready;

   assign ready = ENABLE_MEM_WAIT ? mem_ready : 1'b1;
   assign state = STATE_W'(state_q);

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_n;
   end

   // R-type has no immediate, so it shares the I-format default
   always_comb begin
      imm_src = 3'b000;
      case (op)
         OP_SW:   imm_src = 3'b001;
         OP_BEQ:  imm_src = 3'b010;
         OP_JAL:  imm_src = 3'b011;
         OP_LUI:  imm_src = 3'b100;
         default: imm_src = 3'b000;
      endcase
   end

   always_comb begin
      state_n    = S_FETCH;
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = ready;
            pc_write   = ready;
            state_n    = ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op)
               OP_LW, OP_SW: state_n = S_MEMADR;
               OP_R:         state_n = S_EXECR;
               OP_I:         state_n = S_EXECI;
               OP_BEQ:       state_n = S_BEQ;
               OP_JAL:       state_n = S_JAL;
               OP_LUI:       state_n = S_LUI;
               default: begin
                  state_n    = S_FETCH;
                  illegal_op = 1'b1;
                  instr_done = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_n   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            state_n = ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            instr_done = ready;
            state_n    = ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            state_n   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
            state_n   = S_ALUWB;
         end
         S_LUI: begin
            alu_src_a = 2'b11;
            alu_src_b = 2'b01;
            state_n   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_BEQ: begin
            alu_src_a  = 2'b10;
            alu_op     = 2'b01;
            pc_write   = zero;
            instr_done = 1'b1;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            state_n   = S_ALUWB;
         end
         default: state_n = S_FETCH;
      endcase
      // reset suppresses every enable so an abandoned instruction writes nothing
      if (rst) begin
         pc_write   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         instr_done = 1'b0;
         illegal_op = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed vector bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_BAD = 7'b0000000;

   logic       clk, rst, zero, mem_ready;
   logic [6:0] op;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal_op;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic [2:0] imm_src;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   multicycle_ctrl_fsm #(.ENABLE_MEM_WAIT(1'b1), .STATE_W(4)) dut (
      .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
      .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .imm_src(imm_src), .instr_done(instr_done), .illegal_op(illegal_op),
      .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, irw, rw, mw, adr;
      logic [1:0] rs, sa, sb, aop;
      logic [2:0] imm;
      logic       done, ill;
   } outs_t;

   typedef struct {
      logic       rst;
      logic [6:0] op;
      logic       zero;
      logic       rdy;
      outs_t      exp;
   } vec_t;

   vec_t tbl[$];

   function automatic outs_t mk(input logic [3:0] st, input logic pcw, irw, rw, mw, adr,
                                input logic [1:0] rs, sa, sb, aop, input logic done, ill);
      outs_t o;
      o.st = st; o.pcw = pcw; o.irw = irw; o.rw = rw; o.mw = mw; o.adr = adr;
      o.rs = rs; o.sa = sa; o.sb = sb; o.aop = aop; o.imm = 3'b000;
      o.done = done; o.ill = ill;
      return o;
   endfunction

   // hand-computed expected decode for each state
   function automatic outs_t e_f(input logic r);  return mk(0, r, r, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0); endfunction
   function automatic outs_t e_d();               return mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0); endfunction
   function automatic outs_t e_dbad();            return mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 1, 1); endfunction
   function automatic outs_t e_ma();              return mk(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0); endfunction
   function automatic outs_t e_mr();              return mk(3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0); endfunction
   function automatic outs_t e_mwb();             return mk(4, 0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0); endfunction
   function automatic outs_t e_mw(input logic r); return mk(5, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, r, 0); endfunction
   function automatic outs_t e_mwrst();           return mk(5, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0); endfunction
   function automatic outs_t e_xr();              return mk(6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0); endfunction
   function automatic outs_t e_xi();              return mk(7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0); endfunction
   function automatic outs_t e_aw();              return mk(8, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0); endfunction
   function automatic outs_t e_bq(input logic z); return mk(9, z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 1, 0); endfunction
   function automatic outs_t e_jl();              return mk(10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0); endfunction
   function automatic outs_t e_lu();              return mk(11, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b00, 0, 0); endfunction

   task automatic add(input logic r, input logic [6:0] o, input logic z, input logic rdy,
                      input outs_t e, input logic [2:0] imm);
      vec_t v;
      v.rst = r; v.op = o; v.zero = z; v.rdy = rdy; v.exp = e; v.exp.imm = imm;
      tbl.push_back(v);
   endtask

   function automatic outs_t sample();
      outs_t a;
      a.st = state; a.pcw = pc_write; a.irw = ir_write; a.rw = reg_write; a.mw = mem_write;
      a.adr = adr_src; a.rs = result_src; a.sa = alu_src_a; a.sb = alu_src_b; a.aop = alu_op;
      a.imm = imm_src; a.done = instr_done; a.ill = illegal_op;
      return a;
   endfunction

   task automatic check_outs(input string name, input outs_t got, input outs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got st=%0d pcw%b irw%b rw%b mw%b adr%b rs%b sa%b sb%b aop%b imm%b done%b ill%b, expected st=%0d pcw%b irw%b rw%b mw%b adr%b rs%b sa%b sb%b aop%b imm%b done%b ill%b",
                  name, got.st, got.pcw, got.irw, got.rw, got.mw, got.adr, got.rs, got.sa, got.sb, got.aop, got.imm, got.done, got.ill,
                  exp.st, exp.pcw, exp.irw, exp.rw, exp.mw, exp.adr, exp.rs, exp.sa, exp.sb, exp.aop, exp.imm, exp.done, exp.ill);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // LW with a chosen number of wait cycles in FETCH and MEMREAD, starting from reset
   task automatic run_lw(input int fw, input int mw);
      int fl = fw;
      int ml = mw;
      int done_cyc = 0;
      int ir_cnt = 0;
      int rw_cnt = 0;
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'b1; op = OP_LW; zero = 1'b0;
      for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
         @(negedge clk);
         rst = 1'b0;
         mem_ready = 1'b1;
         if (state == 4'd0 && fl > 0) begin mem_ready = 1'b0; fl--; end
         if (state == 4'd3 && ml > 0) begin mem_ready = 1'b0; ml--; end
         #1;
         if (ir_write) ir_cnt++;
         if (reg_write) rw_cnt++;
         if (instr_done) done_cyc = c;
      end
      check_int($sformatf("lw_cycles_f%0d_m%0d", fw, mw), done_cyc, 5 + fw + mw);
      check_int($sformatf("lw_ir_pulses_f%0d_m%0d", fw, mw), ir_cnt, 1);
      check_int($sformatf("lw_rw_pulses_f%0d_m%0d", fw, mw), rw_cnt, 1);
   endtask

   initial begin
      rst = 1'b1; op = OP_R; zero = 1'b0; mem_ready = 1'b1;

      // reset held two cycles, then addi / add / lui straight-line
      add(1, OP_R, 0, 1, e_f(0), 3'b000);
      add(1, OP_R, 0, 1, e_f(0), 3'b000);
      add(0, OP_I, 0, 1, e_f(1), 3'b000);
      add(0, OP_I, 0, 1, e_d(),  3'b000);
      add(0, OP_I, 0, 1, e_xi(), 3'b000);
      add(0, OP_I, 0, 1, e_aw(), 3'b000);
      add(0, OP_R, 0, 1, e_f(1), 3'b000);
      add(0, OP_R, 0, 1, e_d(),  3'b000);
      add(0, OP_R, 0, 1, e_xr(), 3'b000);
      add(0, OP_R, 0, 1, e_aw(), 3'b000);
      add(0, OP_LUI, 0, 1, e_f(1), 3'b100);
      add(0, OP_LUI, 0, 1, e_d(),  3'b100);
      add(0, OP_LUI, 0, 1, e_lu(), 3'b100);
      add(0, OP_LUI, 0, 1, e_aw(), 3'b100);
      // lw: 2 fetch waits, 3 memread waits, 10 cycles total
      add(0, OP_LW, 0, 0, e_f(0), 3'b000);
      add(0, OP_LW, 0, 0, e_f(0), 3'b000);
      add(0, OP_LW, 0, 1, e_f(1), 3'b000);
      add(0, OP_LW, 0, 1, e_d(),  3'b000);
      add(0, OP_LW, 0, 1, e_ma(), 3'b000);
      add(0, OP_LW, 0, 0, e_mr(), 3'b000);
      add(0, OP_LW, 0, 0, e_mr(), 3'b000);
      add(0, OP_LW, 0, 0, e_mr(), 3'b000);
      add(0, OP_LW, 0, 1, e_mr(), 3'b000);
      add(0, OP_LW, 0, 1, e_mwb(), 3'b000);
      // sw: 2 waits in memwrite
      add(0, OP_SW, 0, 1, e_f(1), 3'b001);
      add(0, OP_SW, 0, 1, e_d(),  3'b001);
      add(0, OP_SW, 0, 1, e_ma(), 3'b001);
      add(0, OP_SW, 0, 0, e_mw(0), 3'b001);
      add(0, OP_SW, 0, 0, e_mw(0), 3'b001);
      add(0, OP_SW, 0, 1, e_mw(1), 3'b001);
      // beq taken, beq not taken, jal
      add(0, OP_BEQ, 1, 1, e_f(1), 3'b010);
      add(0, OP_BEQ, 1, 1, e_d(),  3'b010);
      add(0, OP_BEQ, 1, 1, e_bq(1), 3'b010);
      add(0, OP_BEQ, 0, 1, e_f(1), 3'b010);
      add(0, OP_BEQ, 0, 1, e_d(),  3'b010);
      add(0, OP_BEQ, 0, 1, e_bq(0), 3'b010);
      add(0, OP_JAL, 0, 1, e_f(1), 3'b011);
      add(0, OP_JAL, 0, 1, e_d(),  3'b011);
      add(0, OP_JAL, 0, 1, e_jl(), 3'b011);
      add(0, OP_JAL, 0, 1, e_aw(), 3'b011);
      // illegal opcode returns to fetch
      add(0, OP_BAD, 0, 1, e_f(1), 3'b000);
      add(0, OP_BAD, 0, 1, e_dbad(), 3'b000);
      add(0, OP_BAD, 0, 0, e_f(0), 3'b000);
      // reset while stalled in memwrite
      add(0, OP_SW, 0, 1, e_f(1), 3'b001);
      add(0, OP_SW, 0, 1, e_d(),  3'b001);
      add(0, OP_SW, 0, 1, e_ma(), 3'b001);
      add(0, OP_SW, 0, 0, e_mw(0), 3'b001);
      add(1, OP_SW, 0, 0, e_mwrst(), 3'b001);
      add(0, OP_SW, 0, 0, e_f(0), 3'b001);

      foreach (tbl[i]) begin
         @(negedge clk);
         rst = tbl[i].rst; op = tbl[i].op; zero = tbl[i].zero; mem_ready = tbl[i].rdy;
         #1;
         check_outs($sformatf("row%0d", i), sample(), tbl[i].exp);
      end

      run_lw(0, 0);
      run_lw(1, 2);
      run_lw(3, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
